fir_mac_engine: RTL and testbench

Multiply-accumulate sequencer that feeds the processor core's dedicated FIR write-back port on the register file. On `start` it seeds a 32-bit accumulator, then consumes exactly TAPS sample/coefficient pairs over a valid/ready stream. It writes the final sum to a destination register through `fir_we`/`fir_waddr`/`fir_wdata`. The register file gives this port priority over the normal `rd` write in the same cycle.

---
 rtl/fir_mac_engine_if.sv | 22 ++
 rtl/fir_mac_engine.sv | 145 ++++++++++++++
 tb/tb_fir_mac_engine.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_engine_if.sv
// Sample/coefficient valid-ready stream feeding fir_mac_engine.
// master: upstream producer of sample pairs; slave: the MAC engine.
interface fir_mac_engine_if;
    logic               sample_valid;
    logic               sample_ready;
    logic signed [15:0] sample;
    logic signed [15:0] coeff;

    modport master (
        output sample_valid,
        output sample,
        output coeff,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample,
        input  coeff,
        output sample_ready
    );
endinterface

// File: rtl/fir_mac_engine.sv
// FIR multiply-accumulate sequencer driving the register-file FIR write-back port.
// Seeds a 32-bit accumulator on start, consumes TAPS sample/coeff pairs over
// the stream interface, then writes the sum to the latched destination register.
// Optional feature: define FIR_SATURATE_EN for per-step saturating accumulation
// (default build wraps modulo 2^32).
module fir_mac_engine #(
    parameter int TAPS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [4:0]          dest,
    input  logic [31:0]         accum_in,
    input  logic                init_sel,
    fir_mac_engine_if.slave     sif,
    output logic                fir_we,
    output logic [4:0]          fir_waddr,
    output logic [31:0]         fir_wdata,
    output logic                busy,
    output logic                done
);

    localparam int CW = (TAPS > 2) ? $clog2(TAPS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_WRITE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_acc;
    logic [CW-1:0]      r_count;
    logic [4:0]         r_dest;
    logic [4:0]         r_waddr;
    logic [31:0]        r_wdata;

    logic               w_ready;
    logic               w_hs;
    logic               w_last;
    logic signed [31:0] w_prod;
    logic [31:0]        w_acc_next;

    assign w_prod = sif.sample * sif.coeff;
    assign w_hs   = sif.sample_valid && w_ready;
    assign w_last = (r_count == CW'(TAPS - 1));

`ifdef FIR_SATURATE_EN
    logic [32:0] w_sum33;
    assign w_sum33 = {r_acc[31], r_acc} + {w_prod[31], w_prod};

    // Per-step clamp: a 33-bit sum whose top two bits differ has left the 32-bit range.
    always_comb begin
        w_acc_next = w_sum33[31:0];
        if (w_sum33[32] != w_sum33[31]) begin
            w_acc_next = w_sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end
`else
    assign w_acc_next = r_acc + w_prod;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and state-decoded control outputs.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        fir_we       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_MAC;
                end
            end
            ST_MAC: begin
                // Ready is withheld during reset so an upstream pair is never seen as consumed.
                w_ready = !reset;
                busy    = 1'b1;
                if (w_hs && w_last) begin
                    w_next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy         = 1'b1;
                done         = 1'b1;
                fir_we       = (r_dest != 5'd0);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign sif.sample_ready = w_ready;
    assign fir_waddr        = r_waddr;
    assign fir_wdata        = r_wdata;

    // Accumulator, tap counter, latched destination and write-back output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc   <= '0;
            r_count <= '0;
            r_dest  <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dest  <= dest;
                        r_acc   <= init_sel ? accum_in : '0;
                        r_count <= '0;
                    end
                end
                ST_MAC: begin
                    if (w_hs) begin
                        r_acc   <= w_acc_next;
                        r_count <= r_count + CW'(1);
                        // Write-back values are loaded with the final step so they are
                        // valid during WRITE and hold afterwards.
                        if (w_last) begin
                            r_waddr <= r_dest;
                            r_wdata <= w_acc_next;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine (TAPS=4) with a reference sum model.
module tb_fir_mac_engine;

    localparam int TAPS = 4;

    typedef logic signed [15:0] vec_t [TAPS];

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  dest;
    logic [31:0] accum_in;
    logic        init_sel;
    logic        fir_we;
    logic [4:0]  fir_waddr;
    logic [31:0] fir_wdata;
    logic        busy;
    logic        done;

    int nvec  = 0;
    int nfail = 0;

    fir_mac_engine_if sif ();

    fir_mac_engine #(.TAPS(TAPS)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dest      (dest),
        .accum_in  (accum_in),
        .init_sel  (init_sel),
        .sif       (sif.slave),
        .fir_we    (fir_we),
        .fir_waddr (fir_waddr),
        .fir_wdata (fir_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed arithmetic on wide integers, then wrap or clamp each step.
    function automatic logic [31:0] model(input logic isel, input logic [31:0] seed,
                                          input vec_t s, input vec_t c);
        longint acc;
        logic [63:0] tmp;
        acc = isel ? longint'($signed(seed)) : 64'sd0;
        for (int i = 0; i < TAPS; i++) begin
            acc = acc + longint'(s[i]) * longint'(c[i]);
`ifdef FIR_SATURATE_EN
            if (acc > 64'sd2147483647)  acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`else
            tmp = acc;
            acc = longint'($signed(tmp[31:0]));
`endif
        end
        tmp = acc;
        return tmp[31:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // mode: 0 valid held high, 1 valid low on alternate cycles, 2 random bubbles.
    task automatic run_op(input string tag, input logic [4:0] d, input logic isel,
                          input logic [31:0] seed, input vec_t s, input vec_t c,
                          input int mode, input bit mid_start);
        logic [31:0] exp;
        int idx     = 0;
        int cyc     = 1;
        int bubbles = 0;
        bit got     = 0;
        bit early   = 0;
        bit v;
        bit acc_now;
        exp      = model(isel, seed, s, c);
        start    = 1'b1;
        dest     = d;
        init_sel = isel;
        accum_in = seed;
        tick();
        start    = 1'b0;
        dest     = 5'($urandom);
        init_sel = 1'($urandom);
        accum_in = $urandom;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        while (cyc <= 64) begin
            if (done) begin
                got = 1;
                break;
            end
            if (fir_we) early = 1;
            start   = (mid_start && cyc == 2);
            acc_now = 0;
            if (idx < TAPS) begin
                v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
                sif.sample_valid = v;
                if (v) begin
                    sif.sample = s[idx];
                    sif.coeff  = c[idx];
                    acc_now    = sif.sample_ready;
                end else begin
                    sif.sample = 16'($urandom);
                    sif.coeff  = 16'($urandom);
                    bubbles++;
                end
            end else begin
                sif.sample_valid = 1'b0;
            end
            tick();
            if (acc_now) idx++;
            cyc++;
        end
        start            = 1'b0;
        sif.sample_valid = 1'b0;
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        if (got) begin
            check({tag, "_wdata"}, fir_wdata, exp);
            check({tag, "_we"}, {31'b0, fir_we}, {31'b0, d != 5'd0});
            if (d != 5'd0) check({tag, "_waddr"}, {27'b0, fir_waddr}, {27'b0, d});
            check({tag, "_latency"}, cyc, TAPS + 1 + bubbles);
            check({tag, "_ready_wr"}, {31'b0, sif.sample_ready}, 32'd0);
            check({tag, "_early_we"}, {31'b0, early}, 32'd0);
        end
        tick();
        check({tag, "_done_clr"}, {31'b0, done}, 32'd0);
        check({tag, "_idle"}, {30'b0, busy, fir_we}, 32'd0);
    endtask

    initial begin
        vec_t s, c;
        reset            = 1'b1;
        start            = 1'b0;
        dest             = '0;
        accum_in         = '0;
        init_sel         = 1'b0;
        sif.sample_valid = 1'b0;
        sif.sample       = '0;
        sif.coeff        = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        check("rst_ready", {31'b0, sif.sample_ready}, 32'd0);
        check("rst_we",    {31'b0, fir_we}, 32'd0);
        check("rst_waddr", {27'b0, fir_waddr}, 32'd0);
        check("rst_wdata", fir_wdata, 32'd0);
        check("rst_busy",  {31'b0, busy}, 32'd0);
        check("rst_done",  {31'b0, done}, 32'd0);

        s = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        c = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        run_op("basic", 5'd5, 1'b0, 32'd0, s, c, 0, 0);
        check("basic_const", fir_wdata, 32'd10);
        run_op("bp", 5'd5, 1'b0, 32'd0, s, c, 1, 0);
        check("bp_const", fir_wdata, 32'd10);
        run_op("midstart", 5'd5, 1'b0, 32'd0, s, c, 0, 1);

        s = '{16'sd2, 16'sd2, 16'sd2, 16'sd2};
        c = '{16'sd3, 16'sd3, 16'sd3, 16'sd3};
        run_op("seed", 5'd7, 1'b1, 32'd100, s, c, 0, 0);
        check("seed_const", fir_wdata, 32'd124);
        s = '{-16'sd2, -16'sd2, -16'sd2, -16'sd2};
        run_op("neg", 5'd9, 1'b1, 32'd0, s, c, 0, 0);
        check("neg_const", fir_wdata, 32'hFFFF_FFE8);

        s = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        c = s;
        run_op("ovf", 5'd3, 1'b1, 32'h7FFF_FF00, s, c, 0, 0);
`ifdef FIR_SATURATE_EN
        check("ovf_const", fir_wdata, 32'h7FFF_FFFF);
`else
        check("ovf_const", fir_wdata, 32'h7FFB_FF04);
`endif

        s = '{16'sd5, 16'sd6, 16'sd7, 16'sd8};
        c = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
        run_op("dest0", 5'd0, 1'b0, 32'd0, s, c, 0, 0);

        // Abort after two handshakes, with a pair offered during reset.
        start    = 1'b1;
        dest     = 5'd12;
        init_sel = 1'b0;
        tick();
        start            = 1'b0;
        sif.sample_valid = 1'b1;
        sif.sample       = 16'sd9;
        sif.coeff        = 16'sd9;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset            = 1'b0;
        sif.sample_valid = 1'b0;
        check("abort_busy",  {31'b0, busy}, 32'd0);
        check("abort_we",    {31'b0, fir_we}, 32'd0);
        check("abort_ready", {31'b0, sif.sample_ready}, 32'd0);
        check("abort_wdata", fir_wdata, 32'd0);
        tick(); tick();
        check("abort_quiet", {30'b0, fir_we, done}, 32'd0);
        s = '{16'sd1, 16'sd1, 16'sd1, 16'sd1};
        run_op("post_rst", 5'd12, 1'b0, 32'd0, s, s, 0, 0);
        check("post_rst_const", fir_wdata, 32'd4);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < TAPS; i++) begin
                s[i] = 16'($urandom);
                c[i] = 16'($urandom);
            end
            run_op("rand", 5'($urandom), 1'($urandom), $urandom, s, c, 2, (n % 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
